// File: rtl/lcd_pkg.sv
// Shared types, default 50 MHz timing and LCD command codes for the nibble writer.
// Used by lcd_nibble_strobe and lcd_nibble_writer.
package lcd_pkg;

    localparam int T_SETUP_DEF = 2;
    localparam int T_PULSE_DEF = 12;
    localparam int T_HOLD_DEF  = 1;
    localparam int T_GAP_DEF   = 50;
    localparam int T_EXEC_DEF  = 2000;
    localparam int T_CLEAR_DEF = 82000;
    localparam int T_PWRUP_DEF = 750000;
    localparam int T_INIT1_DEF = 205000;
    localparam int T_INIT2_DEF = 5000;
    localparam int CW_DEF      = 20;

    localparam logic [7:0] LCD_CMD_CLEAR = 8'h01;
    localparam logic [7:0] LCD_CMD_HOME  = 8'h02;

    typedef enum logic [2:0] {
        ST_INIT_WAIT,
        ST_INIT_STROBE,
        ST_INIT_DELAY,
        ST_IDLE,
        ST_HI_NIB,
        ST_GAP,
        ST_LO_NIB,
        ST_EXEC_WAIT
    } wr_state_e;

    typedef enum logic [1:0] {
        SB_IDLE,
        SB_SETUP,
        SB_PULSE,
        SB_HOLD
    } strobe_state_e;

    // Clear and home need the long execution wait; only as commands (RS=0).
    function automatic logic is_long_cmd(input logic rs, input logic [7:0] b);
        return !rs && ((b == LCD_CMD_CLEAR) || (b == LCD_CMD_HOME));
    endfunction

endpackage

// File: rtl/lcd_nibble_strobe.sv
// One E-strobed nibble: SETUP, PULSE (E high), HOLD. start_i begins SETUP on the same edge;
// done_o is high during the last HOLD cycle so the caller can advance without a bubble.
module lcd_nibble_strobe
    import lcd_pkg::*;
#(
    parameter int T_SETUP = T_SETUP_DEF,
    parameter int T_PULSE = T_PULSE_DEF,
    parameter int T_HOLD  = T_HOLD_DEF,
    parameter int CW      = CW_DEF
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       start_i,
    input  logic [3:0] nibble_i,
    input  logic       rs_i,
    output logic       e_o,
    output logic       rs_o,
    output logic [3:0] data_o,
    output logic       done_o
);

    strobe_state_e   state_q;
    logic [CW-1:0]   cnt_q;
    logic            e_q;
    logic            rs_q;
    logic [3:0]      data_q;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= SB_IDLE;
            cnt_q   <= '0;
            e_q     <= 1'b0;
            rs_q    <= 1'b0;
            data_q  <= 4'h0;
        end else begin
            case (state_q)
                SB_IDLE: begin
                    if (start_i) begin
                        data_q  <= nibble_i;
                        rs_q    <= rs_i;
                        cnt_q   <= CW'(T_SETUP - 1);
                        state_q <= SB_SETUP;
                    end
                end
                SB_SETUP: begin
                    if (cnt_q == '0) begin
                        e_q     <= 1'b1;
                        cnt_q   <= CW'(T_PULSE - 1);
                        state_q <= SB_PULSE;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                SB_PULSE: begin
                    if (cnt_q == '0) begin
                        e_q     <= 1'b0;
                        cnt_q   <= CW'(T_HOLD - 1);
                        state_q <= SB_HOLD;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                SB_HOLD: begin
                    // Data and RS stay put after this; they are only reloaded on start.
                    if (cnt_q == '0) begin
                        state_q <= SB_IDLE;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                default: state_q <= SB_IDLE;
            endcase
        end
    end

    assign e_o    = e_q;
    assign rs_o   = rs_q;
    assign data_o = data_q;
    assign done_o = (state_q == SB_HOLD) && (cnt_q == '0);

endmodule

// File: rtl/lcd_nibble_writer.sv
// Byte-to-nibble writer for a 4-bit character LCD: valid/ready byte in, two timed E strobes out.
// Define LCD_INIT_EN to run the power-on 4-bit-mode init sequence before accepting bytes.
module lcd_nibble_writer
    import lcd_pkg::*;
#(
    parameter int T_SETUP = T_SETUP_DEF,
    parameter int T_PULSE = T_PULSE_DEF,
    parameter int T_HOLD  = T_HOLD_DEF,
    parameter int T_GAP   = T_GAP_DEF,
    parameter int T_EXEC  = T_EXEC_DEF,
    parameter int T_CLEAR = T_CLEAR_DEF,
    parameter int T_PWRUP = T_PWRUP_DEF,
    parameter int T_INIT1 = T_INIT1_DEF,
    parameter int T_INIT2 = T_INIT2_DEF,
    parameter int CW      = CW_DEF
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [7:0] iData,
    input  logic       iRS,
    input  logic       iValid,
    output logic       oReady,
    output logic       oInitDone,
    output logic       LCD_E,
    output logic       LCD_RS,
    output logic       LCD_RW,
    output logic [3:0] SF_DATA
);

    wr_state_e      state_q;
    logic [CW-1:0]  cnt_q;
    logic [7:0]     data_q;
    logic           rs_q;
    logic           ready_q;
    logic           init_done_q;

    logic           strb_start;
    logic [3:0]     strb_nibble;
    logic           strb_rs;
    logic           strb_done;

`ifdef LCD_INIT_EN
    logic [1:0]     init_step_q;
    logic [CW-1:0]  init_delay;

    // Wait after each init strobe: 4.1 ms, 100 us, then normal execution time twice.
    always_comb begin
        case (init_step_q)
            2'd0:    init_delay = CW'(T_INIT1 - 1);
            2'd1:    init_delay = CW'(T_INIT2 - 1);
            default: init_delay = CW'(T_EXEC - 1);
        endcase
    end
`else
    logic unused_init_timing;
    assign unused_init_timing = ^{CW'(T_PWRUP), CW'(T_INIT1), CW'(T_INIT2)};
`endif

    always_comb begin
        strb_start  = 1'b0;
        strb_nibble = 4'h0;
        strb_rs     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (iValid && ready_q) begin
                    strb_start  = 1'b1;
                    strb_nibble = iData[7:4];
                    strb_rs     = iRS;
                end
            end
            ST_GAP: begin
                if (cnt_q == '0) begin
                    strb_start  = 1'b1;
                    strb_nibble = data_q[3:0];
                    strb_rs     = rs_q;
                end
            end
`ifdef LCD_INIT_EN
            ST_INIT_WAIT: begin
                if (cnt_q == CW'(T_PWRUP - 1)) begin
                    strb_start  = 1'b1;
                    strb_nibble = 4'h3;
                end
            end
            ST_INIT_DELAY: begin
                if ((cnt_q == '0) && (init_step_q != 2'd3)) begin
                    strb_start  = 1'b1;
                    strb_nibble = (init_step_q == 2'd2) ? 4'h2 : 4'h3;
                end
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
`ifdef LCD_INIT_EN
            state_q     <= ST_INIT_WAIT;
            init_step_q <= 2'd0;
`else
            state_q     <= ST_IDLE;
`endif
            cnt_q       <= '0;
            data_q      <= 8'h00;
            rs_q        <= 1'b0;
            ready_q     <= 1'b0;
            init_done_q <= 1'b0;
        end else begin
            case (state_q)
`ifdef LCD_INIT_EN
                // The counter is cleared by reset, so the power-up wait counts up from 0.
                ST_INIT_WAIT: begin
                    if (strb_start) begin
                        state_q <= ST_INIT_STROBE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                ST_INIT_STROBE: begin
                    if (strb_done) begin
                        cnt_q   <= init_delay;
                        state_q <= ST_INIT_DELAY;
                    end
                end
                ST_INIT_DELAY: begin
                    if (cnt_q == '0) begin
                        if (init_step_q == 2'd3) begin
                            ready_q     <= 1'b1;
                            init_done_q <= 1'b1;
                            state_q     <= ST_IDLE;
                        end else begin
                            init_step_q <= init_step_q + 2'd1;
                            state_q     <= ST_INIT_STROBE;
                        end
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
`endif
                ST_IDLE: begin
                    if (!init_done_q) begin
                        init_done_q <= 1'b1;
                        ready_q     <= 1'b1;
                    end
                    if (strb_start) begin
                        data_q  <= iData;
                        rs_q    <= iRS;
                        ready_q <= 1'b0;
                        state_q <= ST_HI_NIB;
                    end
                end
                ST_HI_NIB: begin
                    if (strb_done) begin
                        cnt_q   <= CW'(T_GAP - 1);
                        state_q <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (strb_start) begin
                        state_q <= ST_LO_NIB;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                ST_LO_NIB: begin
                    if (strb_done) begin
                        cnt_q   <= is_long_cmd(rs_q, data_q) ? CW'(T_CLEAR - 1) : CW'(T_EXEC - 1);
                        state_q <= ST_EXEC_WAIT;
                    end
                end
                ST_EXEC_WAIT: begin
                    if (cnt_q == '0) begin
                        ready_q <= 1'b1;
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    lcd_nibble_strobe #(
        .T_SETUP (T_SETUP),
        .T_PULSE (T_PULSE),
        .T_HOLD  (T_HOLD),
        .CW      (CW)
    ) u_strobe (
        .clk_i    (Clock),
        .rst_n_i  (Reset),
        .start_i  (strb_start),
        .nibble_i (strb_nibble),
        .rs_i     (strb_rs),
        .e_o      (LCD_E),
        .rs_o     (LCD_RS),
        .data_o   (SF_DATA),
        .done_o   (strb_done)
    );

    assign oReady    = ready_q;
    assign oInitDone = init_done_q;
    assign LCD_RW    = 1'b0;

endmodule

// File: tb/tb_lcd_nibble_writer.sv
// Directed + random bench for lcd_nibble_writer with short timings; expectations come from a
// cycle-arithmetic model of strobes and ready timing. Honours LCD_INIT_EN like the design.
module tb_lcd_nibble_writer;

    localparam int S     = 2;
    localparam int P     = 3;
    localparam int H     = 1;
    localparam int GAP   = 4;
    localparam int EXEC  = 10;
    localparam int CLR   = 30;
    localparam int PWR   = 20;
    localparam int INIT1 = 8;
    localparam int INIT2 = 6;

    logic       Clock = 1'b0;
    logic       Reset = 1'b0;
    logic [7:0] iData = 8'h00;
    logic       iRS = 1'b0;
    logic       iValid = 1'b0;
    logic       oReady, oInitDone, LCD_E, LCD_RS, LCD_RW;
    logic [3:0] SF_DATA;

    always #5 Clock = ~Clock;

    lcd_nibble_writer #(
        .T_SETUP (S), .T_PULSE (P), .T_HOLD (H), .T_GAP (GAP), .T_EXEC (EXEC),
        .T_CLEAR (CLR), .T_PWRUP (PWR), .T_INIT1 (INIT1), .T_INIT2 (INIT2), .CW (20)
    ) dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .iData     (iData),
        .iRS       (iRS),
        .iValid    (iValid),
        .oReady    (oReady),
        .oInitDone (oInitDone),
        .LCD_E     (LCD_E),
        .LCD_RS    (LCD_RS),
        .LCD_RW    (LCD_RW),
        .SF_DATA   (SF_DATA)
    );

    typedef struct { int t; logic [3:0] nib; logic rs; } pulse_t;
    typedef struct { int t; logic [7:0] b; logic rs; } acc_t;

    pulse_t     exp_q[$];
    acc_t       acc_q[$];
    int         n_checks = 0;
    int         n_pass = 0;
    int         cyc = 0;
    int         exp_ready = -1;
    int         rise_t = 0;
    int         stable_bad = 0;
    int         rw_bad = 0;
    logic       prev_e = 1'b0;
    logic       prev_ready = 1'b0;
    logic [3:0] rise_nib = 4'h0;
    logic       rise_rs = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed %0d, expected %0d (cycle %0d)", tag, obs, expv, cyc);
    endtask

    function automatic int exec_len(input logic [7:0] b, input logic rs);
        return (!rs && (b == 8'h01 || b == 8'h02)) ? CLR : EXEC;
    endfunction

    // Accepted byte: high nibble rises S clocks after the accept edge, low nibble after
    // PULSE+HOLD+GAP+SETUP more; ready returns after the second HOLD plus execution wait.
    task automatic expect_byte(input int acc, input logic [7:0] b, input logic rs);
        pulse_t p;
        acc_t   a;
        p.t = acc + S;                     p.nib = b[7:4]; p.rs = rs; exp_q.push_back(p);
        p.t = acc + S + P + H + GAP + S;   p.nib = b[3:0]; p.rs = rs; exp_q.push_back(p);
        exp_ready = acc + 2 * (S + P + H) + GAP + exec_len(b, rs);
        a.t = acc; a.b = b; a.rs = rs; acc_q.push_back(a);
        $display("tx: accept byte %02h rs=%0d at cycle %0d, ready expected at %0d", b, rs, acc, exp_ready);
    endtask

    task automatic step();
        logic       v, rdy, r, rst;
        logic [7:0] d;
        pulse_t     p;
        v = iValid; rdy = oReady; d = iData; r = iRS; rst = Reset;
        @(posedge Clock);
        #1;
        cyc++;
        if (LCD_RW !== 1'b0) rw_bad++;
        if (rst) begin
            if (v && rdy === 1'b1) begin
                expect_byte(cyc, d, r);
                chk("ready_drop", oReady, 0);
            end
            if (LCD_E && !prev_e) begin
                chk("pulse_expected", 32'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    p = exp_q.pop_front();
                    chk("rise_cycle", cyc, p.t);
                    chk("nibble", SF_DATA, p.nib);
                    chk("rs", LCD_RS, p.rs);
                end
                rise_nib = SF_DATA; rise_rs = LCD_RS; rise_t = cyc;
            end else if (LCD_E && (SF_DATA !== rise_nib || LCD_RS !== rise_rs)) begin
                stable_bad++;
            end
            if (!LCD_E && prev_e) chk("e_width", cyc - rise_t, P);
            if (oReady === 1'b1 && prev_ready !== 1'b1) begin
                chk("ready_cycle", cyc, exp_ready);
                chk("init_done", oInitDone, 1);
            end
        end
        prev_e = LCD_E;
        prev_ready = oReady;
    endtask

    task automatic do_reset();
        int t;
        pulse_t p;
        Reset = 1'b0;
        iValid = 1'b0;
        step();
        chk("rst_e", LCD_E, 0);
        chk("rst_ready", oReady, 0);
        chk("rst_init_done", oInitDone, 0);
        chk("rst_sf_data", SF_DATA, 0);
        chk("rst_rs", LCD_RS, 0);
        exp_q.delete();
        Reset = 1'b1;
`ifdef LCD_INIT_EN
        t = cyc + PWR + S;              p.t = t; p.nib = 4'h3; p.rs = 1'b0; exp_q.push_back(p);
        t = t + P + H + INIT1 + S;      p.t = t; p.nib = 4'h3; exp_q.push_back(p);
        t = t + P + H + INIT2 + S;      p.t = t; p.nib = 4'h3; exp_q.push_back(p);
        t = t + P + H + EXEC + S;       p.t = t; p.nib = 4'h2; exp_q.push_back(p);
        exp_ready = t + P + H + EXEC;
`else
        t = cyc;
        exp_ready = t + 1;
`endif
        $display("tx: reset released after cycle %0d, ready expected at %0d", cyc, exp_ready);
    endtask

    task automatic wait_ready(input int limit);
        int n = 0;
        while (oReady !== 1'b1 && n < limit) begin
            step();
            n++;
        end
        if (oReady !== 1'b1) chk("ready_timeout", oReady, 1);
    endtask

    task automatic send(input logic [7:0] b, input logic rs);
        wait_ready(500);
        iData = b;
        iRS = rs;
        iValid = 1'b1;
        step();
        iValid = 1'b0;
        wait_ready(500);
    endtask

    initial begin
        int i0;
        int n;
        step();
        do_reset();
        wait_ready(500);

        send(8'h41, 1'b1);
        send(8'h01, 1'b0);
        send(8'h02, 1'b0);
        send(8'h01, 1'b1);
        send(8'hF0, 1'b0);
        repeat (6) send(8'($urandom), 1'($urandom_range(0, 1)));

        // iValid held high with data changing every cycle while busy.
        i0 = acc_q.size();
        iValid = 1'b1;
        for (int k = 0; k < 60; k++) begin
            iData = 8'($urandom);
            iRS = 1'($urandom_range(0, 1));
            step();
        end
        iValid = 1'b0;
        wait_ready(500);
        chk("held_accepts", 32'(acc_q.size() - i0 >= 2), 1);
        if (acc_q.size() - i0 >= 2)
            chk("held_period", acc_q[i0 + 1].t - acc_q[i0].t,
                2 * (S + P + H) + GAP + exec_len(acc_q[i0].b, acc_q[i0].rs) + 1);

        // Reset while E is high during the first nibble.
        iData = 8'hA5; iRS = 1'b1; iValid = 1'b1;
        step();
        iValid = 1'b0;
        n = 0;
        while (LCD_E !== 1'b1 && n < 50) begin
            step();
            n++;
        end
        chk("reached_pulse", LCD_E, 1);
        do_reset();
        wait_ready(500);
        send(8'h55, 1'b1);
        send(8'h02, 1'b0);

        repeat (5) step();
        chk("rw_low", rw_bad, 0);
        chk("data_stable_while_e", stable_bad, 0);
        chk("pending_pulses", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
